// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - state_t : the twelve main-FSM states
//   - ALU_*   : 3-bit operation codes understood by the ALU
//   - OP_*    : instruction opcodes (instr[31:26])
//   - FN_*    : R-type function codes (instr[5:0])
//   - ALUOP_* : internal 2-bit request from the FSM to the ALU decoder
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;  // A & ~B
    localparam logic [2:0] ALU_ORN  = 3'b101;  // A | ~B
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: purely combinational.
//   alu_op    in  : 00=ADD, 01=SUB, 10=decode funct (11 treated as ADD)
//   funct     in  : R-type function field
//   alu_cont  out : 3-bit ALU operation code
//   bad_funct out : funct not supported while alu_op requests funct decode
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_cont,
    output logic       bad_funct
);

    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alu_cont  = ALU_ADD;
        bad_funct = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_cont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_cont = ALU_ADD;
                    FN_SUB:  alu_cont = ALU_SUB;
                    FN_AND:  alu_cont = ALU_AND;
                    FN_OR:   alu_cont = ALU_OR;
                    FN_SLT:  alu_cont = ALU_SLT;
                    default: bad_funct = 1'b1;  // unsupported: fall back to ADD
                endcase
            end
            default: alu_cont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   op, funct   : instruction fields; op sampled in DECODE, funct in EXECUTE
//   zero        : ALU zero flag, only consulted in BRANCH
//   alu_cont    : ALU operation code
//   alu_src_a/b, pc_src, iord, reg_dst, mem_to_reg : datapath mux selects
//   pc_en, mem_write, ir_write, reg_write           : datapath write enables
//   illegal_op  : one-cycle pulse on unsupported opcode (DECODE) or funct (EXECUTE)
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_cont,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    logic       mem_is_load;  // lw vs sw, remembered from DECODE since op may change afterwards
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       illegal_dec;
    logic       bad_funct;

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op),
        .funct     (funct),
        .alu_cont  (alu_cont),
        .bad_funct (bad_funct)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            mem_is_load <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                mem_is_load <= (op == OP_LW);
            end
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALUOP_ADD;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal_dec = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target (PC+4 + imm<<2) is computed here speculatively.
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state  = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = mem_is_load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = S_FETCH;  // unused encodings recover
        endcase

        // During reset present FETCH selects but suppress every write so an
        // aborted instruction leaves no partial side effect.
        if (reset) begin
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b01;
            alu_op      = ALUOP_ADD;
            pc_src      = 2'b00;
            iord        = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            pc_write    = 1'b0;
            branch      = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            illegal_dec = 1'b0;
        end
    end

    // Combinational on zero so the branch resolves in the same BRANCH cycle.
    assign pc_en = pc_write | (branch & zero);

    // bad_funct can only rise while alu_op requests funct decode, i.e. in EXECUTE.
    assign illegal_op = illegal_dec | bad_funct;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
- Sits directly upstream of the ALU. Drives its 3-bit ALU control code every cycle.
- Also drives datapath mux selects and write enables for instruction fetch, register file, memory and PC.
- Consumes the ALU zero flag for branch resolution.

Parameters:
- none (instruction set fixed: lw, sw, R-type, beq, addi, j)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  6  instruction [31:26] from instruction register
- funct  input  6  instruction [5:0]
- zero  input  1  ALU zero flag, same cycle
- alu_cont  output  3  ALU operation code
- alu_src_a  output  1  0=PC, 1=register A
- alu_src_b  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_src  output  2  00=ALU result, 01=ALUOut register, 10=jump target
- pc_en  output  1  PC load enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  data memory write
- ir_write  output  1  instruction register load
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=memory data
- reg_write  output  1  register file write
- illegal_op  output  1  1-cycle pulse on unsupported opcode/funct

Behaviour:
- Reset and sampling:
  - reset sampled on clk rise; state <= FETCH.
  - While reset=1: pc_en, mem_write, ir_write, reg_write and illegal_op are forced 0. All other outputs show FETCH values.
- Output timing:
  - Outputs are decoded from state only; no registered-output latency.
  - pc_en is the one exception: pc_en = pc_write | (branch & zero), combinational on zero.
- ALU codes (shared package): AND=000, OR=001, ADD=010, A&~B=100, A|~B=101, SUB=110, SLT=111.
- alu_op (internal, 2 bits): 00=ADD, 01=SUB, 10=decode funct.
- funct decode:
  - 100000 -> ADD
  - 100010 -> SUB
  - 100100 -> AND
  - 100101 -> OR
  - 101010 -> SLT
  - any other -> ADD, with illegal_op=1 in EXECUTE.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- States and asserted outputs (unlisted enables are 0; unlisted selects are 0):
  - FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00, pc_write=1. -> DECODE
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target).
    - lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - any other op -> FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. -> MEMWB
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. -> FETCH
  - MEMWR: iord=1, mem_write=1. -> FETCH
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct. -> ALUWB
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. -> FETCH
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, branch=1. -> FETCH
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=ADD. -> ADDIWB
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. -> FETCH
  - JUMP: pc_src=10, pc_write=1. -> FETCH
- Latencies: lw 5 cycles; sw, R, addi 4; beq, j 3; illegal 2.
- Boundary conditions:
  - Reset mid-instruction aborts it: the next state is FETCH and no partial write is issued in the reset cycle.
  - op/funct may change in any state except DECODE and EXECUTE; they are sampled only there.
  - zero is ignored outside BRANCH.
  - An unknown state encoding recovers to FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - enum typedef for the 12 FSM states
  - 3-bit ALU code localparams
  - 6-bit opcode and funct localparams
  - 2-bit alu_op encodings
- One sub-module, alu_decoder: purely combinational, (alu_op, funct) -> (alu_cont, bad_funct).
- Top instantiates alu_decoder and contains the FSM.

Test Plan:
- Reset, lw: hold reset 2 cycles, release, op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - FETCH: ir_write=1, pc_en=1, alu_cont=010.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - Back in FETCH on cycle 6.
- sw then R-type: op=101011 -> mem_write=1 only in cycle 4.
  - Then op=0, funct=101010 -> EXECUTE alu_cont=111; ALUWB reg_dst=1, reg_write=1.
- beq: in BRANCH, alu_cont=110, pc_src=01.
  - zero=1 -> pc_en=1; zero=0 -> pc_en=0.
  - Toggle zero within BRANCH: pc_en follows it combinationally.
- j and addi:
  - op=000010 -> JUMP pc_src=10, pc_en=1, 3 cycles total.
  - op=001000 -> ADDIEX alu_src_b=10, alu_cont=010; ADDIWB reg_write=1, reg_dst=0.
- Illegal:
  - op=111111 -> illegal_op=1 in DECODE, next state FETCH, no write enables.
  - op=0, funct=000000 -> alu_cont=010, illegal_op=1 in EXECUTE.
- Reset mid-operation: assert reset during MEMWR -> mem_write=0 that cycle, FETCH next edge.
